// File: rtl/intpol2_nch_core.sv
// intpol2_nch_core: NCH-channel 3-point quadratic interpolator, one shared controller
// Ports: clk, rst (async, active-high); start + cfg_bypass/cfg_step/cfg_len launch a run;
//   Empty_i/RE_o read the input FIFOs, data_in valid one cycle after RE_o;
//   Afull_i/WE_o/data_out write the output FIFOs, data_out valid while WE_o is high;
//   status_reg = {5'b0, cfg_err, busy, done}.
// Define INTPOL2_ROUND_EN to round both fixed-point product scalings half-up instead of truncating.
module intpol2_nch_core #(
    parameter int NCH          = 2,
    parameter int DATA_WIDTH   = 12,
    parameter int N_bits       = 4,
    parameter int M_bits       = 11,
    parameter int CONFIG_WIDTH = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           cfg_bypass,
    input  logic [N_bits+M_bits-1:0]       cfg_step,
    input  logic [CONFIG_WIDTH-1:0]        cfg_len,
    input  logic                           Empty_i,
    input  logic                           Afull_i,
    input  logic [NCH*DATA_WIDTH-1:0]      data_in,
    output logic                           RE_o,
    output logic                           WE_o,
    output logic [NCH*DATA_WIDTH-1:0]      data_out,
    output logic [7:0]                     status_reg
);
    localparam int XW = N_bits + M_bits;
    localparam int CW = DATA_WIDTH + 3;
    localparam int PW = CW + 2 * XW + 4;
    localparam logic [XW:0] ONE = (XW + 1)'(1) << M_bits;
    localparam logic signed [PW-1:0] MAXV = PW'(2 ** (DATA_WIDTH - 1) - 1);
    localparam logic signed [PW-1:0] MINV = -MAXV - PW'(1);
`ifdef INTPOL2_ROUND_EN
    localparam logic signed [PW-1:0] RND = PW'(1) << (M_bits - 1);
`else
    localparam logic signed [PW-1:0] RND = '0;
`endif
    typedef enum logic [2:0] {IDLE, CONFIG, LOAD, COEF, INTERP, SHIFT, BYP, DONE} state_t;
    state_t state_q, state_d;
    logic [XW-1:0] step_q;
    logic [CONFIG_WIDTH-1:0] len_q, cnt_q;
    logic [XW:0] x_q, x_nxt;
    logic err_q, rd_q, we_q, x_one, cfg_err, rd_want;
    logic signed [DATA_WIDTH-1:0] m0_q [NCH], m1_q [NCH], m2_q [NCH];
    logic signed [CW-1:0] p0_q [NCH], p1_q [NCH], p2_q [NCH], avg [NCH], c1 [NCH], c2 [NCH];
    logic signed [PW-1:0] xs, t1 [NCH], t2 [NCH], y [NCH];
    logic [NCH*DATA_WIDTH-1:0] dout_q, y_pk;
    // x carries one extra integer bit so x+step never wraps (x<1.0 before the add)
    assign x_one = |x_q[XW:M_bits];
    assign x_nxt = x_q + {1'b0, step_q};
    assign cfg_err = cfg_bypass ? cfg_len == '0 : (cfg_step == '0 || cfg_len < CONFIG_WIDTH'(3));
    // SHIFT issues one read at a time so x is always up to date when deciding the next one
    assign rd_want = state_q == LOAD  ? cnt_q < CONFIG_WIDTH'(3) :
                     state_q == SHIFT ? x_one && !rd_q && cnt_q < len_q :
                     state_q == BYP   ? cnt_q < len_q && !Afull_i : 1'b0;
    assign RE_o = rd_want && !Empty_i;
    assign WE_o = we_q;
    assign data_out = dout_q;
    assign status_reg = {5'b0, err_q, state_q != IDLE, state_q == DONE};
    always_comb begin
        xs = PW'($signed({1'b0, x_q}));
        y_pk = '0;
        for (int k = 0; k < NCH; k++) begin
            avg[k] = (CW'(m0_q[k]) + CW'(m2_q[k])) >>> 1;
            c2[k] = avg[k] - CW'(m1_q[k]);
            c1[k] = (CW'(m1_q[k]) <<< 1) - CW'(m0_q[k]) - avg[k];
            t1[k] = xs * PW'(p2_q[k]);
            t2[k] = xs * (PW'(p1_q[k]) + ((t1[k] + RND) >>> M_bits));
            y[k] = PW'(p0_q[k]) + ((t2[k] + RND) >>> M_bits);
            y_pk[k*DATA_WIDTH +: DATA_WIDTH] = y[k] > MAXV ? MAXV[DATA_WIDTH-1:0] :
                                               y[k] < MINV ? MINV[DATA_WIDTH-1:0] : y[k][DATA_WIDTH-1:0];
        end
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? CONFIG : IDLE;
            CONFIG:  state_d = cfg_err ? DONE : cfg_bypass ? BYP : LOAD;
            LOAD:    state_d = (rd_q && cnt_q == CONFIG_WIDTH'(3)) ? COEF : LOAD;
            COEF:    state_d = INTERP;
            INTERP:  state_d = (!Afull_i && x_nxt >= ONE) ? SHIFT : INTERP;
            SHIFT:   state_d = rd_q ? SHIFT : !x_one ? COEF : cnt_q == len_q ? DONE : SHIFT;
            BYP:     state_d = (rd_q && cnt_q == len_q) ? DONE : BYP;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            step_q <= '0;
            len_q <= '0;
            cnt_q <= '0;
            x_q <= '0;
            err_q <= 1'b0;
            rd_q <= 1'b0;
            we_q <= 1'b0;
            dout_q <= '0;
            for (int k = 0; k < NCH; k++) begin
                m0_q[k] <= '0;
                m1_q[k] <= '0;
                m2_q[k] <= '0;
                p0_q[k] <= '0;
                p1_q[k] <= '0;
                p2_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            rd_q <= RE_o;
            we_q <= 1'b0;
            if (state_q == IDLE && start) err_q <= 1'b0;
            if (state_q == CONFIG) begin
                step_q <= cfg_step;
                len_q <= cfg_len;
                err_q <= cfg_err;
                cnt_q <= '0;
                x_q <= '0;
            end
            if (RE_o) cnt_q <= cnt_q + CONFIG_WIDTH'(1);
            if (rd_q && state_q == BYP) begin
                dout_q <= data_in;
                we_q <= 1'b1;
            end
            // every captured sample slides the 3-sample window by one
            if (rd_q && state_q != BYP) begin
                for (int k = 0; k < NCH; k++) begin
                    m0_q[k] <= m1_q[k];
                    m1_q[k] <= m2_q[k];
                    m2_q[k] <= $signed(data_in[k*DATA_WIDTH +: DATA_WIDTH]);
                end
                if (state_q == SHIFT) x_q <= x_q - ONE;
            end
            if (state_q == COEF) begin
                for (int k = 0; k < NCH; k++) begin
                    p0_q[k] <= CW'(m0_q[k]);
                    p1_q[k] <= c1[k];
                    p2_q[k] <= c2[k];
                end
            end
            if (state_q == INTERP && !Afull_i) begin
                dout_q <= y_pk;
                we_q <= 1'b1;
                x_q <= x_nxt;
            end
        end
    end
endmodule

// File: tb/tb_intpol2_nch_core.sv
// tb_intpol2_nch_core: scoreboard bench for intpol2_nch_core against a sample-position reference model
module tb_intpol2_nch_core;
    localparam int NCH = 2, DW = 12, M = 11, XW = 15, LW = 32;
`ifdef INTPOL2_ROUND_EN
    localparam longint RND = longint'(1) << (M - 1);
`else
    localparam longint RND = 0;
`endif
    localparam longint YMAX = 2 ** (DW - 1) - 1;
    typedef logic [NCH*DW-1:0] word_t;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, cfg_bypass = 1'b0, Empty_i = 1'b1, Afull_i = 1'b0;
    logic [XW-1:0] cfg_step = '0;
    logic [LW-1:0] cfg_len = '0;
    word_t data_in = '0;
    logic RE_o, WE_o;
    word_t data_out;
    logic [7:0] status_reg;
    word_t src[$], fq[$], expq[$];
    int total = 0, passed = 0, done_cnt = 0;
    bit re_seen = 0, afull_force = 0, afull_rand = 0, empty_rand = 0;

    intpol2_nch_core dut (
        .clk(clk), .rst(rst), .start(start), .cfg_bypass(cfg_bypass), .cfg_step(cfg_step),
        .cfg_len(cfg_len), .Empty_i(Empty_i), .Afull_i(Afull_i), .data_in(data_in),
        .RE_o(RE_o), .WE_o(WE_o), .data_out(data_out), .status_reg(status_reg)
    );

    always #5 clk = ~clk;

    task automatic chk(input bit ok, input string name, input longint act, input longint req);
        total++;
        if (ok) passed++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    function automatic word_t pk(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return {b, a};
    endfunction

    // Expected stream: output n sits at input position p = n*step; window starts at floor(p)
    task automatic model(input bit byp, input int step, input int len);
        longint p, f, m0, m1, m2, avg, c1, c2, a, y;
        int b;
        word_t w, w0, w1, w2;
        if (byp) begin
            foreach (src[i]) expq.push_back(src[i]);
            return;
        end
        for (p = 0; p < (longint'(len) - 2) * (longint'(1) << M); p += step) begin
            b = int'(p >> M);
            f = p % (longint'(1) << M);
            w0 = src[b];
            w1 = src[b+1];
            w2 = src[b+2];
            w = '0;
            for (int k = 0; k < NCH; k++) begin
                m0 = $signed(w0[k*DW +: DW]);
                m1 = $signed(w1[k*DW +: DW]);
                m2 = $signed(w2[k*DW +: DW]);
                avg = (m0 + m2) >>> 1;
                c2 = avg - m1;
                c1 = 2 * m1 - m0 - avg;
                a = (f * c2 + RND) >>> M;
                y = m0 + ((f * (c1 + a) + RND) >>> M);
                if (y > YMAX) y = YMAX;
                else if (y < -YMAX - 1) y = -YMAX - 1;
                w[k*DW +: DW] = y[DW-1:0];
            end
            expq.push_back(w);
        end
    endtask

    task automatic load_t1();
        src.delete();
        expq.delete();
        src.push_back(pk(12'h000, 12'h000));
        src.push_back(pk(12'h200, 12'hE00));
        src.push_back(pk(12'h400, 12'hC00));
        src.push_back(pk(12'h600, 12'hA00));
        expq.push_back(pk(12'h000, 12'h000));
        expq.push_back(pk(12'h100, 12'hF00));
        expq.push_back(pk(12'h200, 12'hE00));
        expq.push_back(pk(12'h300, 12'hD00));
    endtask

    task automatic pulse_start(input bit byp, input int step, input int len);
        fq = src;
        cfg_bypass = byp;
        cfg_step = XW'(step);
        cfg_len = LW'(len);
        start = 1'b1;
        @(negedge clk);
        #3;
        start = 1'b0;
    endtask

    task automatic run(input bit byp, input int step, input int len, input bit exp_err, input string tag);
        int d0, n;
        d0 = done_cnt;
        n = 0;
        pulse_start(byp, step, len);
        while (done_cnt == d0 && n < 4000) begin
            @(negedge clk);
            #3;
            n++;
        end
        chk(done_cnt != d0, {tag, " done_timeout"}, n, 4000);
        chk(expq.size() == 0, {tag, " outputs_missing"}, expq.size(), 0);
        chk(status_reg[2] == exp_err, {tag, " cfg_err"}, status_reg[2], exp_err);
        if (exp_err) chk(n <= 2, {tag, " err_done_latency"}, n, 2);
        else chk(fq.size() == 0, {tag, " samples_unread"}, fq.size(), 0);
        repeat (2) @(negedge clk);
        #3;
        chk(done_cnt == d0 + 1, {tag, " done_pulses"}, done_cnt - d0, 1);
        chk(status_reg[1] == 1'b0, {tag, " busy_after_done"}, status_reg[1], 0);
    endtask

    // input FIFO model: pops on each accepted read, data valid one cycle after RE_o
    initial forever begin
        @(negedge clk);
        if (re_seen && fq.size() > 0) data_in = fq.pop_front();
        Afull_i = afull_force || (afull_rand && $urandom_range(0, 3) == 0);
        Empty_i = fq.size() == 0 || (empty_rand && $urandom_range(0, 2) == 0);
        #1;
        if (Empty_i) chk(!RE_o, "re_while_empty", RE_o, 0);
        re_seen = RE_o && !rst;
    end

    initial forever begin
        bit had;
        word_t e;
        @(negedge clk);
        #2;
        if (status_reg[0]) done_cnt++;
        if (WE_o) begin
            had = expq.size() > 0;
            e = had ? expq.pop_front() : '0;
            chk(had && data_out == e, had ? "data_out" : "unexpected_we", data_out, e);
        end
    end

    initial begin
        word_t snap;
        bit ok, b;
        int t, d, len, st;
        repeat (3) @(negedge clk);
        #3;
        chk(RE_o == 1'b0, "reset_re", RE_o, 0);
        chk(WE_o == 1'b0, "reset_we", WE_o, 0);
        chk(data_out == '0, "reset_data", data_out, 0);
        chk(status_reg == 8'h00, "reset_status", status_reg, 0);
        rst = 1'b0;
        empty_rand = 1;
        load_t1();
        run(0, 'h400, 4, 0, "ramp");
        src.delete();
        expq.delete();
        src.push_back(pk(12'h000, 12'h000));
        src.push_back(pk(12'h100, 12'h100));
        src.push_back(pk(12'h400, 12'h400));
        expq.push_back(pk(12'h000, 12'h000));
        expq.push_back(pk(12'h040, 12'h040));
        run(0, 'h400, 3, 0, "quadratic");
        src.delete();
        expq.delete();
        src.push_back(pk(12'h7FF, 12'h7FF));
        src.push_back(pk(12'h7FF, 12'h7FF));
        src.push_back(pk(12'h000, 12'h000));
        expq.push_back(pk(12'h7FF, 12'h7FF));
        expq.push_back(pk(12'h7FF, 12'h7FF));
        run(0, 'h400, 3, 0, "saturate");
        load_t1();
        fork
            run(0, 'h400, 4, 0, "stall");
            begin
                t = 0;
                while (expq.size() > 2 && t < 300) begin
                    @(negedge clk);
                    #4;
                    t++;
                end
                chk(t < 300, "stall_wait", t, 300);
                afull_force = 1;
                @(negedge clk);
                #4;
                snap = data_out;
                ok = 1;
                repeat (5) begin
                    @(negedge clk);
                    #4;
                    if (WE_o || data_out != snap) ok = 0;
                end
                chk(ok, "stall_hold", data_out, snap);
                afull_force = 0;
            end
        join
        src.delete();
        expq.delete();
        for (int j = 0; j < 4; j++) src.push_back(word_t'($urandom()));
        model(1, 0, 4);
        run(1, 0, 4, 0, "bypass");
        src.delete();
        expq.delete();
        run(0, 0, 4, 1, "step0_err");
        run(0, 'h400, 2, 1, "len2_err");
        run(1, 'h400, 0, 1, "bypass_len0_err");
        load_t1();
        pulse_start(0, 'h400, 4);
        t = 0;
        while (expq.size() > 2 && t < 300) begin
            @(negedge clk);
            #3;
            t++;
        end
        chk(t < 300, "reset_wait", t, 300);
        rst = 1'b1;
        #1;
        chk(RE_o == 1'b0, "abort_re", RE_o, 0);
        chk(WE_o == 1'b0, "abort_we", WE_o, 0);
        chk(data_out == '0, "abort_data", data_out, 0);
        chk(status_reg == 8'h00, "abort_status", status_reg, 0);
        fq.delete();
        expq.delete();
        d = done_cnt;
        repeat (3) @(negedge clk);
        #3;
        chk(done_cnt == d, "abort_no_done", done_cnt - d, 0);
        rst = 1'b0;
        load_t1();
        run(0, 'h400, 4, 0, "after_reset");
        afull_rand = 1;
        for (int i = 0; i < 20; i++) begin
            b = $urandom_range(0, 3) == 0;
            len = $urandom_range(3, 10);
            st = $urandom_range('h100, 'h2000);
            src.delete();
            expq.delete();
            for (int j = 0; j < len; j++) src.push_back(word_t'($urandom()));
            model(b, st, len);
            run(b, st, len, 0, b ? "rand_bypass" : "rand_interp");
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
